// File: rtl/writeback_pkg.sv
// Shared pipeline definitions for the writeback stage: result-source encoding
// and the result-select helper also used by the memory-access stage.
package writeback_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    RES_SRC_EXEC = 2'b00,
    RES_SRC_MEM  = 2'b01,
    RES_SRC_PC   = 2'b10,
    RES_SRC_RSVD = 2'b11
  } res_src_e;

  // The reserved encoding falls back to the ALU result.
  function automatic logic [XLEN-1:0] select_result(
    input logic [1:0]      src,
    input logic [XLEN-1:0] exec_data,
    input logic [XLEN-1:0] mem_data,
    input logic [XLEN-1:0] next_pc
  );
    case (res_src_e'(src))
      RES_SRC_MEM: return mem_data;
      RES_SRC_PC:  return next_pc;
      default:     return exec_data;
    endcase
  endfunction

endpackage

// File: rtl/writeback_regfile.sv
// 2-read/1-write integer register file with x0 hardwired to zero and
// same-cycle write-through bypass on both read ports.
module writeback_regfile
  import writeback_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int RESET_REGS = 1,
  parameter int ADDR_W     = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2
);

  logic [XLEN-1:0] regs [NUM_REGS];
  logic            write_ok;

  assign write_ok = we && (waddr != '0);

  generate
    if (RESET_REGS != 0) begin : g_reset_regs
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (write_ok) begin
          regs[waddr] <= wdata;
        end
      end
    end else begin : g_plain_regs
      // Without an array reset, still block writes while reset is held so an
      // in-flight commit is dropped rather than partially applied.
      always_ff @(posedge clk) begin
        if (reset && write_ok) regs[waddr] <= wdata;
      end
    end
  endgenerate

  function automatic logic [XLEN-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (addr == '0)                    return '0;
    else if (write_ok && addr == waddr) return wdata;
    else                               return regs[addr];
  endfunction

  always_comb begin
    rdata1 = read_port(raddr1);
    rdata2 = read_port(raddr2);
  end

endmodule

// File: rtl/writeback.sv
// Final pipeline stage: result select, register-file commit, commit bus for
// forwarding, and the Zicntr cycle/instret counters.
module writeback
  import writeback_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int CNT_WIDTH  = 64,
  parameter int RESET_REGS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic [XLEN-1:0]      exec_data_in,
  input  logic [XLEN-1:0]      mem_data_in,
  input  logic [XLEN-1:0]      next_pc_in,
  input  logic [1:0]           res_src_in,
  input  logic                 rd_write_enable_in,
  input  logic [4:0]           rd_write_addr_in,
  input  logic                 valid_in,
  input  logic [4:0]           rs1_addr,
  input  logic [4:0]           rs2_addr,
  output logic [XLEN-1:0]      rs1_data,
  output logic [XLEN-1:0]      rs2_data,
  output logic                 wb_we,
  output logic [4:0]           wb_addr,
  output logic [XLEN-1:0]      wb_data,
  output logic                 retire,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instret_count
);

  logic                 commit;
  logic [CNT_WIDTH-1:0] cycle_q;
  logic [CNT_WIDTH-1:0] instret_q;

  // A stalled slot is held upstream, so it commits only once stall drops.
  assign commit  = valid_in && !stall;
  assign retire  = commit;
  assign wb_we   = commit && rd_write_enable_in && (rd_write_addr_in != 5'd0);
  assign wb_addr = rd_write_addr_in;
  assign wb_data = select_result(res_src_in, exec_data_in, mem_data_in, next_pc_in);

  writeback_regfile #(
    .NUM_REGS   (NUM_REGS),
    .RESET_REGS (RESET_REGS),
    .ADDR_W     (5)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_we),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_WIDTH'(1);
      if (commit) instret_q <= instret_q + CNT_WIDTH'(1);
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;

endmodule

// File: tb/tb_writeback.sv
// Randomized and directed bench for writeback against a register-array and
// counter reference model.
module tb_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] exec_data_in, mem_data_in, next_pc_in;
  logic [1:0]  res_src_in;
  logic        rd_write_enable_in;
  logic [4:0]  rd_write_addr_in;
  logic        valid_in;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        retire;
  logic [63:0] cycle_count, instret_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_regs [32];
  logic [63:0] m_cycle, m_instret;

  writeback dut (
    .clk                (clk),
    .reset              (reset),
    .stall              (stall),
    .exec_data_in       (exec_data_in),
    .mem_data_in        (mem_data_in),
    .next_pc_in         (next_pc_in),
    .res_src_in         (res_src_in),
    .rd_write_enable_in (rd_write_enable_in),
    .rd_write_addr_in   (rd_write_addr_in),
    .valid_in           (valid_in),
    .rs1_addr           (rs1_addr),
    .rs2_addr           (rs2_addr),
    .rs1_data           (rs1_data),
    .rs2_data           (rs2_data),
    .wb_we              (wb_we),
    .wb_addr            (wb_addr),
    .wb_data            (wb_data),
    .retire             (retire),
    .cycle_count        (cycle_count),
    .instret_count      (instret_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One instruction slot: drive after the falling edge, check the combinational
  // commit view, clock it, then check the counters.
  task automatic step(input logic v, input logic st, input logic [1:0] src,
                      input logic [31:0] ex, input logic [31:0] mem, input logic [31:0] npc,
                      input logic we, input logic [4:0] rd,
                      input logic [4:0] a1, input logic [4:0] a2);
    logic [31:0] res;
    logic        com, exp_we;
    valid_in = v; stall = st; res_src_in = src;
    exec_data_in = ex; mem_data_in = mem; next_pc_in = npc;
    rd_write_enable_in = we; rd_write_addr_in = rd;
    rs1_addr = a1; rs2_addr = a2;
    res    = (src == 2'd1) ? mem : (src == 2'd2) ? npc : ex;
    com    = v && !st;
    exp_we = com && we && (rd != 5'd0);
    #1;
    chk("rs1_data", rs1_data, (a1 == 0) ? 32'd0 : (exp_we && a1 == rd) ? res : m_regs[a1]);
    chk("rs2_data", rs2_data, (a2 == 0) ? 32'd0 : (exp_we && a2 == rd) ? res : m_regs[a2]);
    chk("wb_we", wb_we, exp_we);
    chk("retire", retire, com);
    chk("wb_data", wb_data, res);
    chk("wb_addr", wb_addr, rd);
    @(posedge clk);
    if (exp_we) m_regs[rd] = res;
    m_cycle++;
    if (com) m_instret++;
    @(negedge clk);
    chk("cycle_count", cycle_count, m_cycle);
    chk("instret_count", instret_count, m_instret);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    logic [63:0] cyc0, ins0;
    reset = 1'b0; stall = 1'b0; valid_in = 1'b0; res_src_in = 2'd0;
    exec_data_in = '0; mem_data_in = '0; next_pc_in = '0;
    rd_write_enable_in = 1'b0; rd_write_addr_in = '0;
    rs1_addr = '0; rs2_addr = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_cycle = '0; m_instret = '0;

    // Reset state: all registers read zero, counters zero.
    #12;
    for (int i = 1; i < 32; i++) begin
      rs1_addr = 5'(i);
      #1 chk("reset_reg", rs1_data, 32'd0);
    end
    chk("reset_cycle", cycle_count, 64'd0);
    chk("reset_instret", instret_count, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) idle();
    chk("cycle_after_10", cycle_count, 64'd10);
    chk("instret_after_10", instret_count, 64'd0);

    // Result select for each res_src encoding.
    step(1, 0, 2'b00, 32'h11, 32'h22, 32'h33, 1, 5'd5, 5'd0, 5'd0);
    step(1, 0, 2'b01, 32'h11, 32'h22, 32'h33, 1, 5'd6, 5'd0, 5'd0);
    step(1, 0, 2'b10, 32'h11, 32'h22, 32'h33, 1, 5'd7, 5'd5, 5'd6);
    step(0, 0, 2'b00, 32'h0,  32'h0,  32'h0,  0, 5'd0, 5'd7, 5'd5);
    rs1_addr = 5'd5; #1 chk("x5", rs1_data, 32'h11);
    rs1_addr = 5'd6; #1 chk("x6", rs1_data, 32'h22);
    rs1_addr = 5'd7; #1 chk("x7", rs1_data, 32'h33);
    chk("instret_3", instret_count, 64'd3);
    @(negedge clk); m_cycle++;

    // x0 write is suppressed but still retires; reserved select uses exec.
    step(1, 0, 2'b00, 32'hDEADBEEF, 32'h0, 32'h0, 1, 5'd0, 5'd0, 5'd0);
    step(1, 0, 2'b11, 32'hA5A5_0001, 32'h5A5A, 32'h4, 1, 5'd8, 5'd8, 5'd0);

    // Same-cycle write-through on both ports.
    step(1, 0, 2'b00, 32'hCAFE, 32'h0, 32'h0, 1, 5'd9, 5'd9, 5'd9);
    rs1_addr = 5'd9; #1 chk("x9_array", rs1_data, 32'hCAFE);

    // Flushed bubble with rd enable set: no write, no retire.
    step(0, 0, 2'b00, 32'hBAD, 32'h0, 32'h0, 1, 5'd9, 5'd9, 5'd0);

    // Held instruction under stall commits exactly once.
    cyc0 = cycle_count; ins0 = instret_count;
    for (int i = 0; i < 3; i++) step(1, 1, 2'b00, 32'h55, 32'h0, 32'h0, 1, 5'd3, 5'd3, 5'd0);
    step(1, 0, 2'b00, 32'h55, 32'h0, 32'h0, 1, 5'd3, 5'd3, 5'd0);
    chk("stall_instret_delta", instret_count - ins0, 64'd1);
    chk("stall_cycle_delta", cycle_count - cyc0, 64'd4);

    // instret wraps from all-ones to zero.
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.instret_q;
    chk("instret_preload", instret_count, 64'hFFFF_FFFF_FFFF_FFFF);
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    step(1, 0, 2'b00, 32'h1, 32'h0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    chk("instret_wrap", instret_count, 64'd0);

    // Randomized traffic, read addresses biased toward the destination.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] rd, a1, a2;
      rd = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
           $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), rd, a1, a2);
    end

    // Asynchronous reset in the middle of a stalled slot.
    valid_in = 1'b1; stall = 1'b1; rd_write_enable_in = 1'b1;
    rd_write_addr_in = 5'd3; exec_data_in = 32'h77; res_src_in = 2'b00;
    #2 reset = 1'b0;
    #1;
    chk("async_cycle", cycle_count, 64'd0);
    chk("async_instret", instret_count, 64'd0);
    valid_in = 1'b0;
    for (int i = 1; i < 32; i++) begin
      rs2_addr = 5'(i);
      #1 chk("async_reg", rs2_data, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_cycle = '0; m_instret = '0;
    step(1, 0, 2'b01, 32'h0, 32'h1234, 32'h0, 1, 5'd4, 5'd3, 5'd4);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
